run_controller: RTL

RUN_CONTROLLER -- requirements
Module: run_controller

---
 rtl/run_controller_if.sv | 23 ++
 rtl/run_controller.sv | 97 +++++++++
 2 files changed

// File: rtl/run_controller_if.sv
// rtl/run_controller_if.sv - host/core handshake bundle for run_controller
interface run_controller_if #(
    parameter int CNT_W = 16
);
    logic             go;
    logic             busy;
    logic             start;
    logic             ack;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [CNT_W-1:0] cycles;
    logic             timed_out;

    modport master (
        output go, ack, rsp_ready,
        input  busy, start, rsp_valid, cycles, timed_out
    );

    modport slave (
        input  go, ack, rsp_ready,
        output busy, start, rsp_valid, cycles, timed_out
    );
endinterface

// File: rtl/run_controller.sv
// rtl/run_controller.sv - launches one processor run, times it, reports length/timeout
module run_controller #(
    parameter int START_CYCLES = 2,
    parameter int TIMEOUT      = 4096,
    parameter int CNT_W        = 16
) (
    input  logic               clk,
    input  logic               reset,
    run_controller_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, LAUNCH, RUN, REPORT} state_t;

    localparam logic [3:0]       PH_LAST = 4'(START_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_M1   = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           r_state;
    state_t           w_next;
    logic [3:0]       r_phase;
    logic [CNT_W-1:0] r_cnt;
    logic             r_armed;
    logic             r_start;
    logic             r_busy;
    logic             r_rsp_valid;
    logic [CNT_W-1:0] r_cycles;
    logic             r_timed_out;
    logic             w_timeout_hit;

    assign w_timeout_hit = (r_cnt >= TO_M1);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.go && (r_armed || !bus.ack)) w_next = LAUNCH;
            LAUNCH:  if (r_phase == PH_LAST) w_next = RUN;
            RUN:     if (bus.ack || w_timeout_hit) w_next = REPORT;
            REPORT:  if (bus.rsp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_phase     <= '0;
            r_cnt       <= '0;
            r_armed     <= 1'b1;
            r_start     <= 1'b0;
            r_busy      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_cycles    <= '0;
            r_timed_out <= 1'b0;
        end else begin
            r_start     <= (w_next == LAUNCH);
            r_busy      <= (w_next != IDLE);
            r_rsp_valid <= (w_next == REPORT);
            case (r_state)
                IDLE: begin
                    r_phase <= '0;
                    if (!bus.ack) r_armed <= 1'b1;
                end
                LAUNCH: begin
                    r_phase <= r_phase + 4'd1;
                    r_cnt   <= '0;
                end
                RUN: begin
                    if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_W'(1);
                    // ack takes priority over a simultaneous timeout
                    if (bus.ack) begin
                        r_cycles    <= r_cnt;
                        r_timed_out <= 1'b0;
                    end else if (w_timeout_hit) begin
                        r_cycles    <= TO_VAL;
                        r_timed_out <= 1'b1;
                    end
                end
                REPORT: r_armed <= 1'b0;
                default: r_armed <= r_armed;
            endcase
        end
    end

    assign bus.start     = r_start;
    assign bus.busy      = r_busy;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.cycles    = r_cycles;
    assign bus.timed_out = r_timed_out;
endmodule
